spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Round-robin arbiter and sequencer that shares one `spi_rdwr_bytes` engine among up to four requesters, such as ADC configuration, DAC setup and status polling. It accepts one 1–4 byte SPI transaction per request and drives the engine's `trig`/`writedata`/`byte_num`/`cs_mode` inputs. It returns the engine's `readdata` with a one-cycle acknowledge, or an error pulse on timeout. An optional per-requester lock keeps ownership across chained transfers where CS is held low (`cs_mode` 2'b01).

## Interface
- `NREQ`, default 4: number of requesters; legal range 2–4.
- `TO_W`, default 20: width of the timeout counter.
- `TIMEOUT`, default 20'hFFFFF: WAIT cycles without `spi_finish` before abort; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  NREQ  request per requester; level.
- `req_wdata`  in  32*NREQ  write bytes; requester i uses slice [32i+31:32i]; byte 0 is sent first.
- `req_byte_num`  in  2*NREQ  bytes minus 1.
- `req_cs_mode`  in  2*NREQ  value passed through to the engine's `cs_mode`.
- `req_lock`  in  NREQ  retain the grant after this transaction completes.
- `ack`  out  NREQ  one-cycle completion pulse to the granted requester.
- `err`  out  NREQ  one-cycle timeout pulse to the granted requester.
- `rdata`  out  32  read data; valid while `ack` is high and held until the next completion.
- `busy`  out  1  high when state ≠ IDLE or a lock is held.
- `spi_trig`  out  1  one-cycle trigger to the engine.
- `spi_writedata`  out  32  write data to the engine.
- `spi_byte_num`  out  2  byte count to the engine.
- `spi_cs_mode`  out  2  CS mode to the engine.
- `spi_finish`  in  1  completion pulse from the engine.
- `spi_readdata`  in  32  read data from the engine; valid while `spi_finish` is high.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE.
- **IDLE**
  - If no lock is held: pick the first set `req` bit searching from `ptr` upward, mod NREQ.
  - If a lock is held: consider only the owner `gnt`. If the owner's `req` and `req_lock` are both low, release the lock and arbitrate normally in the same cycle.
  - On a winner: register `gnt`; latch the winner's wdata/byte_num/cs_mode into `spi_*`; go to LOAD.
- **LOAD**
  - `spi_trig` = 1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - `spi_trig` = 0; the counter increments each cycle.
  - On `spi_finish`: register `rdata` ← `spi_readdata`; set `lock_r` ← `req_lock[gnt]`; go to DONE.
  - On counter = TIMEOUT−1 without `spi_finish`: pulse `err[gnt]`, clear `lock_r`, go to IDLE.
  - If `spi_finish` and timeout occur in the same cycle, `spi_finish` wins.
- **DONE**
  - `ack[gnt]` = 1.
  - `ptr` ← `gnt`+1 mod NREQ, unless `lock_r` is set.
  - Go to IDLE.
- `spi_*` fields stay stable from LOAD until the next grant. This satisfies the engine's capture of fields while `trig` is high.
- Requester rules:
  - Hold `req` and its fields stable until `ack` or `err`.
  - Deassert `req` in the cycle after `ack`/`err` unless issuing another transaction.
  - `req[gnt]` changes after the grant are ignored until completion.
- `spi_finish` outside WAIT is ignored.
- `err` does not update `ptr`.
- Reset value of every output is 0, including `spi_cs_mode` 2'b00. State, `ptr`, `gnt`, counter and `lock_r` also reset to 0 / IDLE.
- A reset mid-transaction returns the block to IDLE. A late `spi_finish` from the engine is then ignored.

## Timing
- Request seen in IDLE at cycle N:
  - `spi_trig` high at N+1.
  - WAIT from N+2.
- `spi_finish` at cycle M:
  - `ack` and `rdata` valid at M+1.
  - Back in IDLE at M+2; the earliest next `spi_trig` is M+3.
- `spi_trig` is low for at least 3 cycles between triggers. This guarantees the engine sees a fresh rising edge.
- Timeout: `err` fires TIMEOUT cycles after entering WAIT.
- Arbitration is single-cycle; there is no combinational path from `req` to any output.

## Test plan
- **Single request.** Requester 1 requests with wdata 32'hA5A5_0103, byte_num 1, cs_mode 0. Engine model returns finish with readdata 32'h0000_BEEF. Expect:
  - exactly one `spi_trig`, with `spi_writedata` = 32'hA5A5_0103;
  - `ack[1]` one cycle after `spi_finish`, with `rdata` = 32'h0000_BEEF.
- **Round-robin.** `req` = 4'b1111 held continuously. Expect grant order 0, 1, 2, 3, 0, with exactly one `ack` per transaction and no `spi_trig` while in WAIT.
- **Lock.** Requester 2 issues 2 transfers with `req_lock` = 1, cs_mode 2'b01 then 2'b10, while requester 0 requests throughout. Expect:
  - both transfers granted to 2 back-to-back;
  - requester 0 granted only after 2's second ack with `req_lock` = 0;
  - `busy` high throughout.
- **Timeout.** TIMEOUT = 16 and the engine never finishes. Expect:
  - `err[gnt]` exactly 16 cycles after WAIT entry, with no ack;
  - lock cleared and next request accepted.
- **Finish vs timeout.** `spi_finish` arrives on the timeout cycle. Expect `ack` and no `err`.
- **Reset mid-transaction.** Assert `rst_n` low for 1 cycle during WAIT, then inject a stale `spi_finish`. Expect:
  - all outputs 0 and no `ack`;
  - next request granted to requester 0 first.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_rdwr_bytes engine among NREQ requesters.
// One 1-4 byte transaction per grant, optional lock to chain CS-held transfers.
module spi_bus_arbiter #(
  parameter int          NREQ    = 4,
  parameter int          TO_W    = 20,
  parameter int unsigned TIMEOUT = 20'hFFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_wdata,
  input  logic [2*NREQ-1:0]    req_byte_num,
  input  logic [2*NREQ-1:0]    req_cs_mode,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 spi_trig,
  output logic [31:0]          spi_writedata,
  output logic [1:0]           spi_byte_num,
  output logic [1:0]           spi_cs_mode,
  input  logic                 spi_finish,
  input  logic [31:0]          spi_readdata
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]       state_reg;
  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    gnt_reg;
  logic [TO_W-1:0]  cnt_reg;
  logic             lock_reg;
  logic [31:0]      rdata_reg;
  logic [NREQ-1:0]  ack_reg;
  logic [NREQ-1:0]  err_reg;
  logic             trig_reg;
  logic [31:0]      wdata_reg;
  logic [1:0]       byte_num_reg;
  logic [1:0]       cs_mode_reg;

  // Per-requester views of the flattened field buses.
  logic [31:0]      wdata_arr    [NREQ];
  logic [1:0]       byte_num_arr [NREQ];
  logic [1:0]       cs_mode_arr  [NREQ];
  logic [IW-1:0]    cand_idx     [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IW:0] sum;
      assign wdata_arr[gi]    = req_wdata[32*gi +: 32];
      assign byte_num_arr[gi] = req_byte_num[2*gi +: 2];
      assign cs_mode_arr[gi]  = req_cs_mode[2*gi +: 2];
      // Candidate gi in round-robin order: (ptr + gi) mod NREQ.
      assign sum = {1'b0, ptr_reg} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
    end
  endgenerate

  logic          rr_valid;
  logic [IW-1:0] rr_idx;

  // Walk candidates from the far end so the nearest one to ptr wins.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        rr_valid = 1'b1;
        rr_idx   = cand_idx[k];
      end
    end
  end

  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic          lock_release;

  always_comb begin
    win_valid    = 1'b0;
    win_idx      = '0;
    lock_release = 1'b0;
    if (lock_reg) begin
      if (req[gnt_reg]) begin
        win_valid = 1'b1;
        win_idx   = gnt_reg;
      end else if (!req_lock[gnt_reg]) begin
        // Owner walked away: drop the lock and arbitrate in the same cycle.
        lock_release = 1'b1;
        win_valid    = rr_valid;
        win_idx      = rr_idx;
      end
    end else begin
      win_valid = rr_valid;
      win_idx   = rr_idx;
    end
  end

  logic [IW-1:0] ptr_next;
  assign ptr_next = (gnt_reg == IW'(NREQ - 1)) ? '0 : gnt_reg + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      cnt_reg      <= '0;
      lock_reg     <= 1'b0;
      rdata_reg    <= '0;
      ack_reg      <= '0;
      err_reg      <= '0;
      trig_reg     <= 1'b0;
      wdata_reg    <= '0;
      byte_num_reg <= '0;
      cs_mode_reg  <= '0;
    end else begin
      ack_reg  <= '0;
      err_reg  <= '0;
      trig_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (lock_release) begin
            lock_reg <= 1'b0;
          end
          if (win_valid) begin
            gnt_reg      <= win_idx;
            wdata_reg    <= wdata_arr[win_idx];
            byte_num_reg <= byte_num_arr[win_idx];
            cs_mode_reg  <= cs_mode_arr[win_idx];
            trig_reg     <= 1'b1;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          cnt_reg <= cnt_reg + TO_W'(1);
          // A finish on the timeout cycle still counts as success.
          if (spi_finish) begin
            rdata_reg        <= spi_readdata;
            lock_reg         <= req_lock[gnt_reg];
            ack_reg[gnt_reg] <= 1'b1;
            state_reg        <= DONE;
          end else if (cnt_reg == TO_LAST) begin
            err_reg[gnt_reg] <= 1'b1;
            lock_reg         <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        DONE: begin
          if (!lock_reg) begin
            ptr_reg <= ptr_next;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack           = ack_reg;
  assign err           = err_reg;
  assign rdata         = rdata_reg;
  assign busy          = (state_reg != IDLE) || lock_reg;
  assign spi_trig      = trig_reg;
  assign spi_writedata = wdata_reg;
  assign spi_byte_num  = byte_num_reg;
  assign spi_cs_mode   = cs_mode_reg;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: single request, round-robin, lock, timeout,
// finish-vs-timeout and reset mid-transaction, with a hand-driven engine.
module tb_spi_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_wdata;
  logic [7:0]   req_byte_num;
  logic [7:0]   req_cs_mode;
  logic [3:0]   req_lock;
  logic [3:0]   ack;
  logic [3:0]   err;
  logic [31:0]  rdata;
  logic         busy;
  logic         spi_trig;
  logic [31:0]  spi_writedata;
  logic [1:0]   spi_byte_num;
  logic [1:0]   spi_cs_mode;
  logic         spi_finish;
  logic [31:0]  spi_readdata;

  int n_cmp = 0;
  int n_bad = 0;
  int trig_total = 0;
  int ack_total = 0;
  int t0, a0;

  spi_bus_arbiter #(.NREQ(4), .TO_W(20), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wdata(req_wdata),
    .req_byte_num(req_byte_num), .req_cs_mode(req_cs_mode), .req_lock(req_lock),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .spi_trig(spi_trig),
    .spi_writedata(spi_writedata), .spi_byte_num(spi_byte_num),
    .spi_cs_mode(spi_cs_mode), .spi_finish(spi_finish), .spi_readdata(spi_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spi_trig) trig_total++;
    if (|ack) ack_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] wd, input logic [1:0] bn,
                         input logic [1:0] cs, input logic lk);
    req_wdata[32*i +: 32] = wd;
    req_byte_num[2*i +: 2] = bn;
    req_cs_mode[2*i +: 2] = cs;
    req_lock[i] = lk;
  endtask

  task automatic wait_trig(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (spi_trig) break;
      tick();
    end
    check(tag, 32'(spi_trig), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    req = '0; req_wdata = '0; req_byte_num = '0; req_cs_mode = '0; req_lock = '0;
    spi_finish = 1'b0; spi_readdata = '0;
    do_reset();

    // Reset state
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_trig", 32'(spi_trig), 32'h0);
    check("rst_wdata", spi_writedata, 32'h0);
    check("rst_bn", 32'(spi_byte_num), 32'h0);
    check("rst_cs", 32'(spi_cs_mode), 32'h0);

    // Single request from requester 1
    t0 = trig_total; a0 = ack_total;
    set_req(1, 32'hA5A5_0103, 2'd1, 2'd0, 1'b0);
    req = 4'b0010;
    tick();
    check("single_trig", 32'(spi_trig), 32'd1);
    check("single_wdata", spi_writedata, 32'hA5A5_0103);
    check("single_bn", 32'(spi_byte_num), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_trig_low", 32'(spi_trig), 32'd0);
    tick();
    spi_finish = 1'b1; spi_readdata = 32'h0000_BEEF;
    tick();
    spi_finish = 1'b0;
    check("single_ack", 32'(ack), 32'h2);
    check("single_rdata", rdata, 32'h0000_BEEF);
    req = '0;
    tick();
    check("single_ack_gone", 32'(ack), 32'h0);
    check("single_idle", 32'(busy), 32'd0);
    check("single_ntrig", 32'(trig_total - t0), 32'd1);
    check("single_nack", 32'(ack_total - a0), 32'd1);

    // Round-robin with all four requesting
    do_reset();
    t0 = trig_total; a0 = ack_total;
    for (int i = 0; i < 4; i++) set_req(i, 32'h1000_0000 + 32'(i), 2'd3, 2'd0, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_trig("rr_trig");
      check("rr_wdata", spi_writedata, 32'h1000_0000 + 32'(k % 4));
      tick();
      check("rr_notrig_wait", 32'(spi_trig), 32'd0);
      tick();
      spi_finish = 1'b1; spi_readdata = 32'hD000_0000 + 32'(k);
      tick();
      spi_finish = 1'b0;
      check("rr_ack", 32'(ack), 32'd1 << (k % 4));
      check("rr_rdata", rdata, 32'hD000_0000 + 32'(k));
    end
    req = '0;
    tick();
    tick();
    check("rr_ntrig", 32'(trig_total - t0), 32'd5);
    check("rr_nack", 32'(ack_total - a0), 32'd5);

    // Lock: requester 2 chains two transfers while requester 0 waits
    set_req(2, 32'h2222_0001, 2'd1, 2'b01, 1'b1);
    req = 4'b0100;
    wait_trig("lk1_trig");
    check("lk1_wdata", spi_writedata, 32'h2222_0001);
    check("lk1_cs", 32'(spi_cs_mode), 32'h1);
    set_req(0, 32'h0000_0A0A, 2'd0, 2'd0, 1'b0);
    req = 4'b0101;
    tick();
    check("lk1_busy", 32'(busy), 32'd1);
    tick();
    spi_finish = 1'b1; spi_readdata = 32'h0000_0011;
    tick();
    spi_finish = 1'b0;
    check("lk1_ack", 32'(ack), 32'h4);
    set_req(2, 32'h2222_0002, 2'd1, 2'b10, 1'b0);
    tick();
    check("lk_gap_busy", 32'(busy), 32'd1);
    check("lk_gap_trig", 32'(spi_trig), 32'd0);
    tick();
    check("lk2_trig", 32'(spi_trig), 32'd1);
    check("lk2_wdata", spi_writedata, 32'h2222_0002);
    check("lk2_cs", 32'(spi_cs_mode), 32'h2);
    tick();
    check("lk2_busy", 32'(busy), 32'd1);
    tick();
    spi_finish = 1'b1; spi_readdata = 32'h0000_0022;
    tick();
    spi_finish = 1'b0;
    check("lk2_ack", 32'(ack), 32'h4);
    check("lk2_rdata", rdata, 32'h0000_0022);
    req = 4'b0001;
    wait_trig("lk0_trig");
    check("lk0_wdata", spi_writedata, 32'h0000_0A0A);
    tick();
    tick();
    spi_finish = 1'b1; spi_readdata = 32'h0000_0033;
    tick();
    spi_finish = 1'b0;
    check("lk0_ack", 32'(ack), 32'h1);
    req = '0;
    tick();

    // Timeout with lock requested: err after 16 WAIT cycles, lock dropped
    a0 = ack_total;
    set_req(1, 32'h3333_0000, 2'd0, 2'b01, 1'b1);
    req = 4'b0010;
    wait_trig("to_trig");
    tick();
    repeat (15) tick();
    check("to_err_early", 32'(err), 32'h0);
    tick();
    check("to_err", 32'(err), 32'h2);
    check("to_noack", 32'(ack_total - a0), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    set_req(3, 32'h4444_0003, 2'd2, 2'd0, 1'b0);
    req = 4'b1000;
    tick();
    check("to_next_trig", 32'(spi_trig), 32'd1);
    check("to_next_wdata", spi_writedata, 32'h4444_0003);
    check("to_err_gone", 32'(err), 32'h0);

    // Finish arrives on the timeout cycle
    tick();
    repeat (15) tick();
    spi_finish = 1'b1; spi_readdata = 32'h0000_5555;
    tick();
    spi_finish = 1'b0;
    req = '0;
    check("ft_ack", 32'(ack), 32'h8);
    check("ft_noerr", 32'(err), 32'h0);
    check("ft_rdata", rdata, 32'h0000_5555);
    tick();
    check("ft_noerr_late", 32'(err), 32'h0);

    // Move ptr off 0, then reset in the middle of a transaction
    set_req(1, 32'h6666_0001, 2'd0, 2'd0, 1'b0);
    req = 4'b0010;
    wait_trig("mr_pre_trig");
    tick();
    tick();
    spi_finish = 1'b1; spi_readdata = 32'h0000_0077;
    tick();
    spi_finish = 1'b0;
    check("mr_pre_ack", 32'(ack), 32'h2);
    req = '0;
    tick();
    set_req(2, 32'h8888_0002, 2'd3, 2'b01, 1'b0);
    req = 4'b0100;
    wait_trig("mr_trig");
    check("mr_wdata", spi_writedata, 32'h8888_0002);
    tick();
    rst_n = 1'b0;
    req = '0;
    tick();
    rst_n = 1'b1;
    check("mr_ack", 32'(ack), 32'h0);
    check("mr_err", 32'(err), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_trig", 32'(spi_trig), 32'h0);
    check("mr_wdata0", spi_writedata, 32'h0);
    check("mr_bn", 32'(spi_byte_num), 32'h0);
    check("mr_cs", 32'(spi_cs_mode), 32'h0);
    check("mr_rdata", rdata, 32'h0);
    a0 = ack_total;
    spi_finish = 1'b1; spi_readdata = 32'h0000_9999;
    tick();
    spi_finish = 1'b0;
    check("mr_stale_ack", 32'(ack), 32'h0);
    tick();
    check("mr_stale_ack2", 32'(ack), 32'h0);
    check("mr_nack", 32'(ack_total - a0), 32'd0);
    check("mr_rdata_kept", rdata, 32'h0);
    set_req(0, 32'hAAAA_0000, 2'd0, 2'd0, 1'b0);
    set_req(3, 32'hBBBB_0003, 2'd0, 2'd0, 1'b0);
    req = 4'b1101;
    wait_trig("mr_next_trig");
    check("mr_next_wdata", spi_writedata, 32'hAAAA_0000);
    tick();
    tick();
    spi_finish = 1'b1; spi_readdata = 32'h0000_ABCD;
    tick();
    spi_finish = 1'b0;
    check("mr_next_ack", 32'(ack), 32'h1);
    req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
